// File: rtl/ipm_distributed_fifo_v1_3_sync_prefetch.sv
// ipm_distributed_fifo_v1_3_sync_prefetch
// Single-clock first-word-fall-through FIFO. Storage is a distributed RAM
// followed by a registered prefetch stage (dout_reg/dout_vld). Total capacity
// is 2^ADDR_WIDTH + 1 words. A write into an otherwise empty FIFO bypasses
// the RAM and lands directly in the prefetch register.
// Optional feature: define IPM_DIST_FIFO_ERR_FLAG_EN to add the sticky
// overflow/underflow ports.
module ipm_distributed_fifo_v1_3_sync_prefetch #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int ALMOST_FULL_NUM  = 4,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int CAPACITY = DEPTH + 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(CAPACITY - ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  dout_vld;
    logic [DATA_WIDTH-1:0] dout_reg;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  can_load;
    logic                  load_ram;
    logic                  bypass;
    logic                  ram_wr;
    logic [ADDR_WIDTH:0]   mem_cnt_nxt;
    logic                  dout_vld_nxt;

    // Accept qualification, prefetch decisions and next occupancy.
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_acc       = wr_en & ~full;
        rd_acc       = rd_en & ~empty;
        can_load     = ~dout_vld | rd_acc;
        load_ram     = can_load & (mem_cnt != '0);
        bypass       = can_load & (mem_cnt == '0) & wr_acc;
        ram_wr       = wr_acc & ~bypass;
        mem_cnt_nxt  = mem_cnt;
        dout_vld_nxt = dout_vld;

        if (ram_wr && !load_ram) begin
            mem_cnt_nxt = mem_cnt + 1'b1;
        end else if (load_ram && !ram_wr) begin
            mem_cnt_nxt = mem_cnt - 1'b1;
        end

        if (load_ram || bypass) begin
            dout_vld_nxt = 1'b1;
        end else if (rd_acc) begin
            dout_vld_nxt = 1'b0;
        end
    end

    // RAM write port; pointers are reset elsewhere so old contents are never read.
    // NOTE: the storage array has no reset; clearing it would prevent mapping
    // onto distributed RAM and stale words are unreachable anyway.
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, counters, prefetch register and registered water level.
    // NOTE: state registers use non-blocking assignments so that every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            dout_vld    <= 1'b0;
            dout_reg    <= '0;
            water_level <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_ram) begin
                rd_ptr   <= rd_ptr + 1'b1;
                dout_reg <= mem[rd_ptr];
            end else if (bypass) begin
                dout_reg <= wr_data;
            end
            mem_cnt     <= mem_cnt_nxt;
            dout_vld    <= dout_vld_nxt;
            water_level <= mem_cnt_nxt + {{ADDR_WIDTH{1'b0}}, dout_vld_nxt};
        end
    end

`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    // Status outputs decoded from registered state only.
    always_comb begin
        full         = (mem_cnt == DEPTH_LVL);
        empty        = ~dout_vld;
        almost_full  = (water_level >= AF_LVL);
        almost_empty = (water_level <= AE_LVL);
        rd_data      = dout_reg;
    end

endmodule

// File: tb/tb_ipm_distributed_fifo_v1_3_sync_prefetch.sv
// Testbench for ipm_distributed_fifo_v1_3_sync_prefetch (ADDR_WIDTH=4,
// DATA_WIDTH=32). A queue reference model doubles as the scoreboard: words
// are pushed when a write is driven and popped/compared when read out.
// Works with or without IPM_DIST_FIFO_ERR_FLAG_EN defined.
module tb_ipm_distributed_fifo_v1_3_sync_prefetch;

    localparam int CAP = 17;

    logic        clk;
    logic        rst;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        full;
    logic        almost_full;
    logic [31:0] rd_data;
    logic        rd_en;
    logic        empty;
    logic        almost_empty;
    logic [4:0]  water_level;
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
    logic        overflow;
    logic        underflow;
`endif

    ipm_distributed_fifo_v1_3_sync_prefetch #(
        .ADDR_WIDTH       (4),
        .DATA_WIDTH       (32),
        .ALMOST_FULL_NUM  (4),
        .ALMOST_EMPTY_NUM (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .empty        (empty),
        .almost_empty (almost_empty),
        .water_level  (water_level)
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];
    logic [31:0] last_word;
    logic        m_ovf;
    logic        m_udf;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] data;
        logic [4:0]  level;
        logic        empty;
        logic        full;
        logic [31:0] rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the reference model.
    task automatic check_state();
        int lvl;
        lvl = sb.size();
        check("level", 64'(water_level), 64'(lvl));
        check("empty", 64'(empty), 64'(lvl == 0));
        check("full", 64'(full), 64'(lvl == CAP));
        check("almost_full", 64'(almost_full), 64'(lvl >= CAP - 4));
        check("almost_empty", 64'(almost_empty), 64'(lvl <= 4));
        check("rd_data", 64'(rd_data), 64'((lvl > 0) ? sb[0] : last_word));
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("underflow", 64'(underflow), 64'(m_udf));
`endif
    endtask

    // One clock: drive at the falling edge, update model, check at next falling edge.
    task automatic cycle(input logic w, input logic r, input logic [31:0] d);
        logic        wacc;
        logic        racc;
        logic [31:0] head;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        wacc    = w && (sb.size() < CAP);
        racc    = r && (sb.size() > 0);
        if (w && sb.size() == CAP) m_ovf = 1'b1;
        if (r && sb.size() == 0)   m_udf = 1'b1;
        if (racc) begin
            head = sb.pop_front();
            check("sb_pop_data", 64'(rd_data), 64'(head));
            last_word = head;
        end
        if (wacc) sb.push_back(d);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state();
    endtask

    // One reset cycle with the given (ignored) access requests.
    task automatic reset_cycle(input logic w, input logic r);
        rst     = 1'b1;
        wr_en   = w;
        rd_en   = r;
        wr_data = $urandom;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sb.delete();
        last_word = '0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
        check("rst_level", 64'(water_level), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check_state();
    endtask

    initial begin
        vec_t vecs [8];
        vecs[0] = '{1'b1, 1'b0, 32'hA5A5_0001, 5'd1, 1'b0, 1'b0, 32'hA5A5_0001};
        vecs[1] = '{1'b0, 1'b1, 32'h0,         5'd0, 1'b1, 1'b0, 32'hA5A5_0001};
        vecs[2] = '{1'b0, 1'b1, 32'h0,         5'd0, 1'b1, 1'b0, 32'hA5A5_0001};
        vecs[3] = '{1'b1, 1'b0, 32'h2,         5'd1, 1'b0, 1'b0, 32'h2};
        vecs[4] = '{1'b1, 1'b0, 32'h3,         5'd2, 1'b0, 1'b0, 32'h2};
        vecs[5] = '{1'b1, 1'b1, 32'h4,         5'd2, 1'b0, 1'b0, 32'h3};
        vecs[6] = '{1'b0, 1'b1, 32'h0,         5'd1, 1'b0, 1'b0, 32'h4};
        vecs[7] = '{1'b0, 1'b1, 32'h0,         5'd0, 1'b1, 1'b0, 32'h4};

        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        @(negedge clk);
        reset_cycle(1'b0, 1'b0);
        check("rst_almost_empty", 64'(almost_empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);

        // Bypass write/read, empty read and mixed traffic from the table.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].wr, vecs[i].rd, vecs[i].data);
            check($sformatf("vec%0d_level", i), 64'(water_level), 64'(vecs[i].level));
            check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].empty));
            check($sformatf("vec%0d_full", i), 64'(full), 64'(vecs[i].full));
            check($sformatf("vec%0d_rdata", i), 64'(rd_data), 64'(vecs[i].rdata));
        end

        // Fill to capacity, then one dropped write.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 32'(i));
            if (i == 11) check("af_at_12", 64'(almost_full), 64'd0);
            if (i == 12) check("af_at_13", 64'(almost_full), 64'd1);
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_level", 64'(water_level), 64'd17);
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
        check("drop_level", 64'(water_level), 64'd17);
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
        check("drop_overflow", 64'(overflow), 64'd1);
`endif

        // Drain at one word per cycle; data order checked by the scoreboard.
        for (int i = 0; i < 17; i++) begin
            check($sformatf("drain_head%0d", i), 64'(rd_data), 64'(i));
            cycle(1'b0, 1'b1, 32'h0);
            if (i == 0) check("full_clears", 64'(full), 64'd0);
        end
        check("drain_empty", 64'(empty), 64'd1);

        // Steady state at level 5 with simultaneous read/write across wrap.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'(100 + i));
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 32'(200 + i));
            check("steady_level", 64'(water_level), 64'd5);
        end

        // Read from empty: nothing moves, rd_data holds.
        reset_cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h1234_5678);
        cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b1, 32'h0);
        check("udf_hold_data", 64'(rd_data), 64'h1234_5678);
        check("udf_level", 64'(water_level), 64'd0);
`ifdef IPM_DIST_FIFO_ERR_FLAG_EN
        check("udf_flag", 64'(underflow), 64'd1);
`endif

        // Reset at level 9 with both requests asserted, then a fresh write.
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 32'($urandom));
        check("pre_rst_level", 64'(water_level), 64'd9);
        reset_cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'hBEEF_0007);
        check("post_rst_data", 64'(rd_data), 64'hBEEF_0007);
        check("post_rst_level", 64'(water_level), 64'd1);

        // Random mixed traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ipm_distributed_fifo_v1_3_sync_prefetch.md
# ipm_distributed_fifo_v1_3_sync_prefetch

Single-clock, first-word-fall-through (FWFT) FIFO built on distributed RAM with a registered prefetch output stage. It is the synchronous successor to the dual-clock distributed FIFO. It adds bypass-on-empty, a total-occupancy water level, runtime-independent almost thresholds and optional sticky error flags. It sits between packet/UART datapaths and downstream consumers that need valid data on `rd_data` whenever `empty` is low.

## Interface
- `ADDR_WIDTH`, 4: RAM address width, legal 4–10; RAM holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: data width, legal 1–256.
- `ALMOST_FULL_NUM`, 4: almost_full margin below CAPACITY; legal 1..CAPACITY-1.
- `ALMOST_EMPTY_NUM`, 4: almost_empty threshold; legal 1..CAPACITY-1.
- CAPACITY (derived) = 2^ADDR_WIDTH + 1, which is the RAM plus the prefetch register.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_data` in DATA_WIDTH: write data.
- `wr_en` in 1: write request.
- `full` out 1: no write accepted.
- `almost_full` out 1: level ≥ CAPACITY − ALMOST_FULL_NUM.
- `rd_data` out DATA_WIDTH: head word, valid while `empty`=0.
- `rd_en` in 1: pop head word.
- `empty` out 1: prefetch register invalid.
- `almost_empty` out 1: level ≤ ALMOST_EMPTY_NUM.
- `water_level` out ADDR_WIDTH+1: total occupancy, 0..CAPACITY.
- `overflow` out 1: sticky; present only with IPM_DIST_FIFO_ERR_FLAG_EN.
- `underflow` out 1: sticky; present only with IPM_DIST_FIFO_ERR_FLAG_EN.

## Operation
- State:
  - wr_ptr, rd_ptr, ADDR_WIDTH bits each, wrapping modulo 2^ADDR_WIDTH.
  - mem_cnt, 0..2^ADDR_WIDTH.
  - dout_vld.
  - dout_reg.
  - water_level = mem_cnt + dout_vld, held registered.
- Accept rules:
  - write accepted = `wr_en` & ~`full`. A write while full is dropped, even with a simultaneous `rd_en`.
  - read accepted = `rd_en` & ~`empty`. A read while empty is ignored.
- Prefetch register next-state, per cycle, in priority order:
  1. dout_vld=0 or read accepted, and mem_cnt>0: load dout_reg ← mem[rd_ptr], rd_ptr+1, mem_cnt−1, dout_vld=1.
  2. dout_vld=0 or read accepted, mem_cnt=0, and write accepted: bypass, dout_reg ← wr_data, RAM not written, dout_vld=1.
  3. Read accepted and nothing to load: dout_vld=0.
  4. Otherwise: hold.
- A write accepted and not bypassed writes mem[wr_ptr], wr_ptr+1, mem_cnt+1. mem_cnt stays unchanged when one word is loaded from RAM and one written in the same cycle.
- Flags:
  - `full` = (mem_cnt == 2^ADDR_WIDTH), which equals water_level == CAPACITY.
  - `empty` = ~dout_vld.
  - almost flags are comparisons on the registered water_level.
  - All flags are registered or derived from registered state only; there is no combinational path from `wr_en`/`rd_en` to any output.
- `rd_data` = dout_reg; it holds its last value when empty.
- RAM is not cleared by reset; stale RAM contents are unreachable after reset.

## Timing
- Reset values: water_level=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, overflow=0, underflow=0. Pointers and mem_cnt are 0.
- Reset mid-operation: the FIFO is empty on the cycle after the `rst` edge, all contents are discarded, and `wr_en`/`rd_en` during `rst` are ignored.
- Write-to-read latency: a write at edge N into an empty FIFO gives `empty`=0 and `rd_data`=that word after edge N (1 cycle, via bypass).
- Read at edge N: the next word is on `rd_data` after edge N if RAM is non-empty. Back-to-back reads sustain 1 word/cycle.
- Simultaneous read and write, including at level 1 and at full−1: level unchanged, order preserved.
- Flag updates: `full` deasserts one cycle after the read that frees RAM space. Almost flags track water_level in the same cycle.

## Configuration
- `IPM_DIST_FIFO_ERR_FLAG_EN` defined:
  - `overflow` sets on `wr_en`&`full`.
  - `underflow` sets on `rd_en`&`empty`.
  - Both are sticky until `rst`.
- Not defined: the `overflow`/`underflow` ports and their logic are absent. Dropped or ignored accesses are silent; all other behaviour is identical.

## Test plan
- Reset, then single write 0xA5A5_0001 -> after 1 edge: `empty`=0, `rd_data`=0xA5A5_0001, level=1. Then rd_en -> `empty`=1, level=0.
- ADDR_WIDTH=4: write 17 words 0..16 with no reads -> `full`=1, level=17, `almost_full` asserted at level 13. An 18th write is dropped; `overflow`=1 with the macro defined.
- From full, read 17 consecutive cycles -> `rd_data` sequence 0..16, `full` clears after the first read, `empty`=1 after the 17th read, `almost_empty` at level ≤4.
- Level 5, simultaneous rd_en/wr_en for 40 cycles with incrementing data -> level stays 5, output strictly in order across pointer wrap.
- rd_en on an empty FIFO -> no state change, `rd_data` holds, `underflow`=1 (macro defined), port absent otherwise.
- Level 9, assert `rst` for 1 cycle while wr_en=rd_en=1 -> level=0, `empty`=1, flags at reset values. The next write appears on `rd_data` after 1 edge.
